// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of RAM port B with one-cycle read return.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise CPU priority with a MAX_BURST starvation limit.
module mem_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        CPU_RESET_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  input  logic        dbg_lock,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_wren,
  input  logic [15:0] ram_q,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  state_last_grant,
  output logic [3:0]  state_burst_cnt
);

  // Handshake: a requester holds req until it sees gnt at a rising edge; each gnt is one
  // transfer. A granted read returns on rvalid/rdata in the following cycle only.

  typedef enum logic [1:0] {
    LG_NONE = 2'd0,
    LG_CPU  = 2'd1,
    LG_DBG  = 2'd2
  } grant_e;

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);
`endif

  grant_e      last_grant, last_grant_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic        pend_cpu, pend_dbg;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        cpu_win;

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      last_grant <= LG_NONE;
      burst_cnt  <= '0;
      pend_cpu   <= 1'b0;
      pend_dbg   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      pend_cpu   <= cpu_gnt & ~cpu_we;
      pend_dbg   <= dbg_gnt & ~dbg_we;
      if (cpu_gnt || dbg_gnt) begin
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end
      if (pend_cpu || pend_dbg) rdata_q <= ram_q;
    end
  end

  always_comb begin
    cpu_gnt        = 1'b0;
    dbg_gnt        = 1'b0;
    last_grant_nxt = LG_NONE;
    burst_cnt_nxt  = burst_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    cpu_win = (last_grant != LG_CPU);
`else
    cpu_win = (burst_cnt != MAX_B);
`endif
    // Grants are gated by reset so every output is quiet while reset is held.
    if (CPU_RESET_n) begin
      if (dbg_lock) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        cpu_gnt = cpu_win;
        dbg_gnt = ~cpu_win;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
    if (cpu_gnt)      last_grant_nxt = LG_CPU;
    else if (dbg_gnt) last_grant_nxt = LG_DBG;
`ifdef ARB_ROUND_ROBIN_EN
    burst_cnt_nxt = '0;
`else
    if (dbg_gnt || !dbg_req)                burst_cnt_nxt = '0;
    else if (cpu_gnt && burst_cnt != MAX_B) burst_cnt_nxt = burst_cnt + 4'd1;
`endif
  end

  assign ram_addr   = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : addr_q);
  assign ram_wdata  = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : wdata_q);
  assign ram_wren   = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
  assign cpu_rvalid = pend_cpu;
  assign dbg_rvalid = pend_dbg;
  assign busy       = pend_cpu | pend_dbg;
  assign rdata      = busy ? ram_q : rdata_q;

  assign state_last_grant = last_grant;
  assign state_burst_cnt  = burst_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM port B model, policy reference model, directed scenarios
// and a randomized request phase; also covers the ARB_ROUND_ROBIN_EN build.
module tb_mem_port_arbiter;
  localparam int MAX_BURST = 4;

  logic        clk, CPU_RESET_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, ram_wren, busy;
  logic [15:0] ram_addr, ram_wdata, ram_q, rdata;
  logic [1:0]  state_last_grant;
  logic [3:0]  state_burst_cnt;

  mem_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .CPU_RESET_n(CPU_RESET_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .rdata(rdata), .busy(busy),
    .state_last_grant(state_last_grant), .state_burst_cnt(state_burst_cnt)
  );

  // clock / RAM port B model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    ram_q <= ram_mem[ram_addr];
  end

  // reference model and scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mdl_mem [0:65535];
  int          mdl_last;
  int          mdl_streak;
  logic [15:0] mdl_addr, mdl_wdata;
  logic        m_c, m_d;
  logic [16:0] exp_q[$];
  string       gseq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_last = 0;
    mdl_streak = 0;
    mdl_addr = '0;
    mdl_wdata = '0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic apply_reset();
    CPU_RESET_n = 1'b0;
    set_cpu(1'b1, 1'b1, 16'h00F0, 16'h1111);
    set_dbg(1'b1, 1'b1, 16'h00F1, 16'h2222);
    #2;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_last_grant", state_last_grant, 0);
    chk("rst_burst_cnt", state_burst_cnt, 0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    dbg_lock = 1'b0;
    CPU_RESET_n = 1'b1;
    mdl_reset();
  endtask

  // One bus cycle: called just after a falling edge with inputs already driven.
  task automatic do_cycle();
    logic [15:0] ea, ew;
    logic        ewe;
    logic [16:0] e;
    #1;
    m_c = 1'b0;
    m_d = 1'b0;
    if (dbg_lock) begin
      m_d = dbg_req;
    end else if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_c = (mdl_last != 1);
`else
      m_c = (mdl_streak < MAX_BURST);
`endif
      m_d = !m_c;
    end else begin
      m_c = cpu_req;
      m_d = dbg_req;
    end
    ea  = m_c ? cpu_addr  : (m_d ? dbg_addr  : mdl_addr);
    ew  = m_c ? cpu_wdata : (m_d ? dbg_wdata : mdl_wdata);
    ewe = m_c ? cpu_we    : (m_d ? dbg_we    : 1'b0);
    chk("cpu_gnt", cpu_gnt, m_c);
    chk("dbg_gnt", dbg_gnt, m_d);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wdata", ram_wdata, ew);
    chk("ram_wren", ram_wren, ewe);
    gseq = {gseq, m_c ? "C" : (m_d ? "D" : "-")};
    if ((m_c || m_d) && !ewe) exp_q.push_back({m_d, mdl_mem[ea]});
    if (ewe) mdl_mem[ea] = ew;
    if (m_c || m_d) begin
      mdl_addr = ea;
      mdl_wdata = ew;
    end
    if (m_d || !dbg_req) mdl_streak = 0;
    else if (m_c && mdl_streak < MAX_BURST) mdl_streak++;
    mdl_last = m_c ? 1 : (m_d ? 2 : 0);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cpu_rvalid", cpu_rvalid, !e[16]);
      chk("dbg_rvalid", dbg_rvalid, e[16]);
      chk("rdata", rdata, e[15:0]);
      chk("busy", busy, 1);
    end else begin
      chk("cpu_rvalid_idle", cpu_rvalid, 0);
      chk("dbg_rvalid_idle", dbg_rvalid, 0);
      chk("busy_idle", busy, 0);
    end
    chk("last_grant", state_last_grant, mdl_last);
`ifdef ARB_ROUND_ROBIN_EN
    chk("burst_cnt", state_burst_cnt, 0);
`else
    chk("burst_cnt", state_burst_cnt, mdl_streak);
`endif
    @(negedge clk);
  endtask

  int lock_left;

  initial begin
    CPU_RESET_n = 1'b0;
    dbg_lock = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    mdl_reset();
    @(negedge clk);
    apply_reset();

    // preload addresses 0..16 through the debug port; 0x0010 holds 0xBEEF
    for (int i = 0; i <= 16; i++) begin
      set_dbg(1'b1, 1'b1, 16'(i), (i == 16) ? 16'hBEEF : 16'($urandom));
      do_cycle();
    end
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);

    // lone CPU read of 0x0010
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    do_cycle();
    chk("cpu_read_rvalid", cpu_rvalid, 1);
    chk("cpu_read_dbg_rvalid", dbg_rvalid, 0);
    chk("cpu_read_data", rdata, 16'hBEEF);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();

    // sustained contention from reset
    apply_reset();
    gseq = "";
    set_cpu(1'b1, 1'b0, 16'h0003, 16'h0);
    set_dbg(1'b1, 1'b0, 16'h0004, 16'h0);
    for (int i = 0; i < 10; i++) do_cycle();
`ifdef ARB_ROUND_ROBIN_EN
    chk_str("contention_order", gseq, "CDCDCDCDCD");
`else
    chk_str("contention_order", gseq, "CCCCDCCCCD");
`endif

    // debug lock: CPU waits while debug writes 0x1234 to 0x0005
    dbg_lock = 1'b1;
    set_cpu(1'b1, 1'b0, 16'h0005, 16'h0);
    set_dbg(1'b1, 1'b1, 16'h0005, 16'h1234);
    gseq = "";
    for (int i = 0; i < 3; i++) do_cycle();
    chk_str("lock_order", gseq, "DDD");
    dbg_lock = 1'b0;
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();
    chk("lock_readback", rdata, 16'h1234);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);

    // same-address write race
    apply_reset();
    gseq = "";
    set_cpu(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    set_dbg(1'b1, 1'b1, 16'h0020, 16'h5555);
    do_cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    do_cycle();
    chk_str("race_order", gseq, "CDC");
    chk("race_readback", rdata, 16'h5555);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);

    // randomized traffic; a requester holds its request until granted
    lock_left = 0;
    m_c = 1'b1;
    m_d = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || m_c)
        set_cpu($urandom_range(0, 99) < 60, 1'($urandom), 16'($urandom_range(0, 16)), 16'($urandom));
      if (!dbg_req || m_d)
        set_dbg($urandom_range(0, 99) < 50, 1'($urandom), 16'($urandom_range(0, 16)), 16'($urandom));
      if (lock_left > 0) begin
        lock_left--;
      end else begin
        dbg_lock = 1'b0;
        if ($urandom_range(0, 99) < 6) begin
          dbg_lock = 1'b1;
          lock_left = $urandom_range(1, 4);
        end
      end
      do_cycle();
    end
    dbg_lock = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();

    // reset asserted while a CPU read is returning
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    #1;
    chk("midrd_gnt", cpu_gnt, 1);
    @(posedge clk);
    #1;
    chk("midrd_rvalid_before", cpu_rvalid, 1);
    #2;
    CPU_RESET_n = 1'b0;
    #1;
    chk("midrd_rvalid", cpu_rvalid, 0);
    chk("midrd_busy", busy, 0);
    chk("midrd_cpu_gnt", cpu_gnt, 0);
    chk("midrd_rdata", rdata, 0);
    chk("midrd_ram_addr", ram_addr, 0);
    chk("midrd_ram_wren", ram_wren, 0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    CPU_RESET_n = 1'b1;
    mdl_reset();
    do_cycle();
    do_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
